// File: rtl/rto_pkg.sv
// Shared types and helpers for the RTOC write arbiter.
// Holds the arbiter FSM encoding and index-width helpers.
package rto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    // Width needed to index n requesters (never below 1 bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Modulo-n increment of a requester index.
    function automatic int wrap_inc(input int i, input int n);
        return (i >= n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search over a valid vector.
// Returns the first set bit at or after ptr, wrapping around.
module rr_priority_select
    import rto_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      index,
    output logic               found
);

    int cand;

    // Walk the ring starting at ptr; keep the first valid hit.
    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[cand[IW-1:0]]) begin
                found = 1'b1;
                index = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rto_write_arbiter.sv
// Burst-oriented round-robin arbiter for the RTOC_Core FIFO write port.
// An owner keeps the port until its last entry or until flush aborts it.
module rto_write_arbiter
    import rto_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                fifo_write,
    output logic [DATA_WIDTH-1:0]               fifo_din,
    input  logic                                fifo_full,
    output logic [idx_width(NUM_REQ)-1:0]       grant_id,
    output logic                                busy,
    output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   accept_cnt,
    output logic                                abort_pulse
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic [IW-1:0] grant_nxt;
    logic          xfer;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_sel (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .index (sel_idx),
        .found (sel_found)
    );

    assign grant_nxt = IW'(wrap_inc(int'(grant_id), NUM_REQ));

    // Owner handshake: open only in BURST, closed by full or flush.
    always_comb begin
        req_ready = '0;
        if (state == ST_BURST && !fifo_full && !flush) begin
            req_ready[grant_id] = 1'b1;
        end
        xfer       = req_valid[grant_id] && req_ready[grant_id];
        fifo_write = xfer;
        fifo_din   = req_data[grant_id];
    end

    // Arbitration FSM with registered grant, busy, pointer and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            abort_pulse <= 1'b0;
            accept_cnt  <= '0;
        end else begin
            abort_pulse <= 1'b0;
            if (xfer) begin
                accept_cnt[grant_id] <= accept_cnt[grant_id] + 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                    end else if (sel_found) begin
                        grant_id <= sel_idx;
                        busy     <= 1'b1;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (flush) begin
                        abort_pulse <= 1'b1;
                        rr_ptr      <= grant_nxt;
                        busy        <= 1'b0;
                        state       <= ST_FLUSH;
                    end else if (xfer && req_last[grant_id]) begin
                        rr_ptr <= grant_nxt;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (!flush) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rto_write_arbiter.sv
// Self-checking bench for rto_write_arbiter.
// Directed tables, hand sequences and random traffic against a ring model.
module tb_rto_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic                clk;
    logic                reset;
    logic                flush;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_last;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic                fifo_write;
    logic [DW-1:0]       fifo_din;
    logic                fifo_full;
    logic [1:0]          grant_id;
    logic                busy;
    logic [N-1:0][CW-1:0] accept_cnt;
    logic                abort_pulse;

    rto_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_write  (fifo_write),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .grant_id    (grant_id),
        .busy        (busy),
        .accept_cnt  (accept_cnt),
        .abort_pulse (abort_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model: 0 = idle, 1 = owned burst, 2 = flushing.
    int m_mode;
    int m_owner;
    int m_ptr;
    int m_abort;
    int m_cnt [N];

    // Values observed on the last step.
    logic          s_write;
    logic [DW-1:0] s_din;
    logic          s_busy;
    logic [1:0]    s_gid;
    logic          s_abort;
    logic [DW-1:0] got [$];
    int            n_abort;

    typedef struct {
        bit          rs;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        fu;
        logic        fl;
        logic [27:0] dv;
        logic        ew;
        logic [31:0] edin;
        logic        eb;
        logic [1:0]  eg;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_abort = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_write", 32'(fifo_write), 0);
        chk("rst_abort", 32'(abort_pulse), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_cnt", 32'(accept_cnt), 0);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model.
    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic fu, input logic fl,
                        input logic [N-1:0][DW-1:0] d);
        logic [3:0] e_ready;
        logic       e_write;
        bit         hit;
        int         c;
        req_valid = v;
        req_last  = l;
        fifo_full = fu;
        flush     = fl;
        req_data  = d;
        @(negedge clk);
        e_ready = '0;
        if (m_mode == 1 && !fu && !fl) e_ready[m_owner[1:0]] = 1'b1;
        e_write = (m_mode == 1) && !fu && !fl && v[m_owner[1:0]];
        chk("busy", 32'(busy), 32'(m_mode == 1));
        if (m_mode == 1) chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("fifo_write", 32'(fifo_write), 32'(e_write));
        if (e_write) chk("fifo_din", fifo_din, d[m_owner[1:0]]);
        chk("abort_pulse", 32'(abort_pulse), 32'(m_abort));
        for (int i = 0; i < N; i++)
            chk("accept_cnt", 32'(accept_cnt[i]), 32'(m_cnt[i] % 16));
        s_write = fifo_write;
        s_din   = fifo_din;
        s_busy  = busy;
        s_gid   = grant_id;
        s_abort = abort_pulse;
        if (fifo_write) got.push_back(fifo_din);
        if (abort_pulse) n_abort++;
        if (e_write) m_cnt[m_owner]++;
        m_abort = 0;
        if (fl) begin
            if (m_mode == 1) begin
                m_abort = 1;
                m_ptr   = (m_owner + 1) % N;
            end
            m_mode = 2;
        end else if (m_mode == 0) begin
            hit = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!hit && v[c[1:0]]) begin
                    hit     = 1;
                    m_owner = c;
                end
            end
            if (hit) m_mode = 1;
        end else if (m_mode == 1) begin
            if (e_write && l[m_owner[1:0]]) begin
                m_mode = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else begin
            m_mode = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0][DW-1:0] mkd(input logic [27:0] dv);
        logic [N-1:0][DW-1:0] d;
        for (int i = 0; i < N; i++) d[i] = {4'(i), dv};
        return d;
    endfunction

    task automatic add(input bit rs, input logic [3:0] v, input logic [3:0] l,
                       input logic [27:0] dv, input logic ew,
                       input logic [31:0] edin, input logic eb,
                       input logic [1:0] eg);
        vec_t t;
        t.rs = rs; t.v = v; t.l = l; t.fu = 1'b0; t.fl = 1'b0;
        t.dv = dv; t.ew = ew; t.edin = edin; t.eb = eb; t.eg = eg;
        tbl.push_back(t);
    endtask

    initial begin
        logic [N-1:0][DW-1:0] d;
        int idx;
        int first;
        int wf;
        int wfl;
        bit fu;
        n_chk   = 0;
        n_fail  = 0;
        n_abort = 0;
        reset   = 1'b1;
        model_reset();

        // Single burst from requester 2: A, B, C.
        add(1, 4'b0100, 4'b0000, 28'hA, 0, 0,            0, 0);
        add(0, 4'b0100, 4'b0000, 28'hA, 1, 32'h2000000A, 1, 2);
        add(0, 4'b0100, 4'b0000, 28'hB, 1, 32'h2000000B, 1, 2);
        add(0, 4'b0100, 4'b0100, 28'hC, 1, 32'h2000000C, 1, 2);
        add(0, 4'b0000, 4'b0000, 28'h0, 0, 0,            0, 0);
        // Fairness: single-entry bursts from all four, pointer at 0.
        add(1, 4'b1111, 4'b1111, 28'h5, 0, 0,            0, 0);
        add(0, 4'b1111, 4'b1111, 28'h5, 1, 32'h00000005, 1, 0);
        add(0, 4'b1111, 4'b1111, 28'h5, 0, 0,            0, 0);
        add(0, 4'b1111, 4'b1111, 28'h5, 1, 32'h10000005, 1, 1);
        add(0, 4'b1111, 4'b1111, 28'h5, 0, 0,            0, 0);
        add(0, 4'b1111, 4'b1111, 28'h5, 1, 32'h20000005, 1, 2);
        add(0, 4'b1111, 4'b1111, 28'h5, 0, 0,            0, 0);
        add(0, 4'b1111, 4'b1111, 28'h5, 1, 32'h30000005, 1, 3);
        add(0, 4'b1111, 4'b1111, 28'h5, 0, 0,            0, 0);
        add(0, 4'b1111, 4'b1111, 28'h5, 1, 32'h00000005, 1, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rs) do_reset();
            step(tbl[r].v, tbl[r].l, tbl[r].fu, tbl[r].fl, mkd(tbl[r].dv));
            chk("tbl_write", 32'(s_write), 32'(tbl[r].ew));
            if (tbl[r].ew) chk("tbl_din", s_din, tbl[r].edin);
            chk("tbl_busy", 32'(s_busy), 32'(tbl[r].eb));
            if (tbl[r].eb) chk("tbl_gid", 32'(s_gid), 32'(tbl[r].eg));
            if (r == 4) chk("burst_cnt2", 32'(accept_cnt[2]), 3);
        end

        // Backpressure: five full cycles inside requester 3's burst.
        do_reset();
        got.delete();
        idx   = 0;
        first = -1;
        wf    = 0;
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            fu = (first >= 0) && (cyc > first) && (cyc <= first + 5);
            d = '0;
            d[3] = 32'hB0 + 32'(idx);
            step(4'b1000, (idx == 3) ? 4'b1000 : 4'b0000, fu, 1'b0, d);
            if (s_write) begin
                if (fu) wf++;
                if (first < 0) first = cyc;
                idx++;
            end
        end
        chk("bp_done", 32'(idx), 4);
        chk("bp_full_writes", 32'(wf), 0);
        chk("bp_count", 32'(got.size()), 4);
        for (int k = 0; k < got.size() && k < 4; k++)
            chk("bp_order", got[k], 32'hB0 + 32'(k));
        step(4'b0000, 4'b0000, 1'b0, 1'b0, '0);

        // Flush abort after two of requester 1's four entries.
        do_reset();
        d = mkd(28'h11);
        step(4'b0010, 4'b0000, 1'b0, 1'b0, d);
        step(4'b0010, 4'b0000, 1'b0, 1'b0, d);
        step(4'b0010, 4'b0000, 1'b0, 1'b0, mkd(28'h12));
        n_abort = 0;
        wfl     = 0;
        for (int k = 0; k < 2; k++) begin
            step(4'b0110, 4'b0000, 1'b0, 1'b1, mkd(28'h13));
            if (s_write) wfl++;
        end
        step(4'b0110, 4'b0000, 1'b0, 1'b0, mkd(28'h13));
        step(4'b0110, 4'b0000, 1'b0, 1'b0, mkd(28'h13));
        step(4'b0110, 4'b0000, 1'b0, 1'b0, mkd(28'h13));
        chk("fl_abort_once", 32'(n_abort), 1);
        chk("fl_no_write", 32'(wfl), 0);
        chk("fl_busy", 32'(s_busy), 1);
        chk("fl_next_gid", 32'(s_gid), 2);
        chk("fl_cnt1", 32'(accept_cnt[1]), 2);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b0, mkd(28'h21));
        step(4'b0010, 4'b0000, 1'b0, 1'b0, mkd(28'h21));
        req_valid = 4'b0010;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_ready", 32'(req_ready), 0);
        chk("ar_write", 32'(fifo_write), 0);
        chk("ar_abort", 32'(abort_pulse), 0);
        chk("ar_gid", 32'(grant_id), 0);
        chk("ar_cnt", 32'(accept_cnt), 0);
        @(posedge clk);
        #1;
        chk("ar_abort_hold", 32'(abort_pulse), 0);
        reset = 1'b0;
        model_reset();
        step(4'b0000, 4'b0000, 1'b0, 1'b0, '0);

        // Counter wrap: 17 entries from requester 0 on a 4-bit counter.
        do_reset();
        step(4'b0001, 4'b0000, 1'b0, 1'b0, '0);
        for (int k = 0; k < 17; k++)
            step(4'b0001, (k == 16) ? 4'b0001 : 4'b0000, 1'b0, 1'b0,
                 mkd(28'(k)));
        chk("wrap_cnt0", 32'(accept_cnt[0]), 1);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) d[i] = $urandom;
            step(4'($urandom), 4'($urandom & $urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
